// File: rtl/scan_mode_ctrl.sv
// PS/2 scan-code mode controller: make/break/extended decoding, edit/play mode FSM,
// key forwarding to the active edit block, play start/stop handshake, blinking mode LEDs.
module scan_mode_ctrl #(
    parameter int                    NUM_EDIT  = 3,
    parameter logic [NUM_EDIT*8-1:0] KEY_CODES = {8'h3A, 8'h32, 8'h4B},
    parameter logic [7:0]            PLAY_KEY  = 8'h29,
    parameter logic [7:0]            EXIT_KEY  = 8'h5A,
    parameter logic [7:0]            ABORT_KEY = 8'h76,
    parameter int                    BLINK_DIV = 1_250_000,
    parameter logic [31:0]           TIMEOUT   = 32'd500_000_000
) (
    input  logic                CLOCK_50,
    input  logic                nReset,
    input  logic [7:0]          data,
    input  logic                data_en,
    input  logic                bpm_valid,
    input  logic                play_en,
    output logic [NUM_EDIT-1:0] edit_en,
    output logic                play_active,
    output logic                start,
    output logic                stop,
    output logic [7:0]          key_data,
    output logic                key_ext,
    output logic                key_valid,
    output logic [NUM_EDIT:0]   led
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EDIT = 2'd1,
        S_ARM  = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    localparam logic [31:0] BLINK_LAST = 32'(BLINK_DIV - 1);
    localparam logic [31:0] TMO_LAST   = TIMEOUT - 32'd1;

    state_t              state_q, state_d;
    logic [2:0]          mode_q, mode_d;
    logic                brk_q, brk_d, ext_q, ext_d;
    logic [31:0]         tmo_q, tmo_d;
    logic [31:0]         blink_q, blink_d;
    logic                phase_q, phase_d;
    logic                isMake, hit, fwd, stopEv;
    logic [2:0]          hitIdx;

    logic [NUM_EDIT-1:0] editEn_q, editEn_d;
    logic [NUM_EDIT:0]   led_q, led_d;
    logic                playAct_q, start_q, stop_q;
    logic [7:0]          keyData_q;
    logic                keyExt_q, keyValid_q;

    // A byte is a make event only if no F0 preceded it; prefixes are consumed here.
    always_comb begin
        brk_d  = brk_q;
        ext_d  = ext_q;
        isMake = 1'b0;
        if (data_en) begin
            if (data == 8'hF0) begin
                brk_d = 1'b1;
            end else if (data == 8'hE0) begin
                ext_d = 1'b1;
            end else begin
                isMake = !brk_q;
                brk_d  = 1'b0;
                ext_d  = 1'b0;
            end
        end
    end

    // Scan from the top so the lowest matching mode index is the one kept.
    always_comb begin
        hit    = 1'b0;
        hitIdx = '0;
        for (int k = NUM_EDIT - 1; k >= 0; k--) begin
            if (data == KEY_CODES[k*8 +: 8]) begin
                hit    = 1'b1;
                hitIdx = 3'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        fwd     = 1'b0;
        stopEv  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (isMake) begin
                    if (hit) begin
                        state_d = S_EDIT;
                        mode_d  = hitIdx;
                    end else if (data == PLAY_KEY && bpm_valid) begin
                        state_d = S_ARM;
                    end
                end
            end
            S_EDIT: begin
                if (int'(mode_q) >= NUM_EDIT) begin
                    state_d = S_IDLE;
                end else if (isMake) begin
                    if (data == EXIT_KEY) state_d = S_IDLE;
                    else                  fwd     = 1'b1;
                end else if (TIMEOUT != 32'd0 && tmo_q == TMO_LAST) begin
                    state_d = S_IDLE;
                end
            end
            S_ARM: begin
                if (isMake && data == ABORT_KEY) begin
                    state_d = S_IDLE;
                    stopEv  = 1'b1;
                end else if (play_en) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (isMake && data == ABORT_KEY) begin
                    state_d = S_IDLE;
                    stopEv  = 1'b1;
                end else if (!play_en) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Inactivity counter only runs while staying in an edit mode without key strokes.
    always_comb begin
        tmo_d = '0;
        if (TIMEOUT != 32'd0 && state_q == S_EDIT && state_d == S_EDIT && !isMake)
            tmo_d = tmo_q + 32'd1;
        phase_d = phase_q;
        if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            phase_d = ~phase_q;
        end else begin
            blink_d = blink_q + 32'd1;
        end
    end

    always_comb begin
        editEn_d = '0;
        led_d    = '0;
        for (int k = 0; k < NUM_EDIT; k++) begin
            editEn_d[k] = (state_d == S_EDIT) && (mode_d == 3'(k));
            led_d[k]    = editEn_d[k] ? phase_d : 1'b1;
        end
        led_d[NUM_EDIT] = (state_d == S_ARM) || (state_d == S_RUN);
    end

    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            tmo_q       <= '0;
            blink_q     <= '0;
            phase_q     <= 1'b0;
            editEn_q    <= '0;
            led_q       <= '0;
            playAct_q   <= 1'b0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            keyData_q   <= '0;
            keyExt_q    <= 1'b0;
            keyValid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            brk_q       <= brk_d;
            ext_q       <= ext_d;
            tmo_q       <= tmo_d;
            blink_q     <= blink_d;
            phase_q     <= phase_d;
            editEn_q    <= editEn_d;
            led_q       <= led_d;
            playAct_q   <= (state_d == S_ARM) || (state_d == S_RUN);
            start_q     <= (state_d == S_ARM) && (state_q != S_ARM);
            stop_q      <= stopEv;
            keyValid_q  <= fwd;
            if (fwd) begin
                keyData_q <= data;
                keyExt_q  <= ext_q;
            end
        end
    end

    assign edit_en     = editEn_q;
    assign led         = led_q;
    assign play_active = playAct_q;
    assign start       = start_q;
    assign stop        = stop_q;
    assign key_data    = keyData_q;
    assign key_ext     = keyExt_q;
    assign key_valid   = keyValid_q;

endmodule
